// File: rtl/eclair_mul_pkg.sv
// eclair_mul_pkg: shared sizing, rounding, clamp-bound and fit helpers for the ECLAIR multiply pipe.
package eclair_mul_pkg;
    localparam int MAXW = 128;
    typedef logic signed [MAXW-1:0] wide_t;
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction
    function automatic wide_t clamp_hi(input int w, input bit sgn);
        wide_t one = wide_t'(1);
        return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction
    function automatic wide_t clamp_lo(input int w, input bit sgn);
        wide_t one = wide_t'(1);
        return sgn ? -(one <<< (w - 1)) : '0;
    endfunction
    // Values arrive already sign/zero-extended, so >>> is logical for unsigned results.
    function automatic wide_t round_shift(input wide_t v, input int sh);
        wide_t one = wide_t'(1);
        return (sh == 0) ? v : (v + (one <<< (sh - 1))) >>> sh;
    endfunction
    function automatic wide_t fit(input wide_t v, input int w, input bit sgn, input bit sat);
        wide_t hi = clamp_hi(w, sgn);
        wide_t lo = clamp_lo(w, sgn);
        return !sat ? v : (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/eclair_pipe_stage.sv
// eclair_pipe_stage: one valid/ready register slice; loads when empty or when its content advances.
module eclair_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;
    assign w_load  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end
endmodule

// File: rtl/eclair_mul_pipe.sv
// eclair_mul_pipe: pipelined multiply, round-half-up right shift and fit, with valid/ready back-pressure.
// Define ECLAIR_MUL_SAT_EN to clamp instead of wrap and expose sat_flag.
module eclair_mul_pipe
    import eclair_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 9,
    parameter int dout_WIDTH  = 25,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int FRAC_SHIFT  = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_valid,
`ifdef ECLAIR_MUL_SAT_EN
    output logic                  sat_flag,
`endif
    input  logic                  out_ready
);
    localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
    localparam bit RS = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam int NQ = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
`ifdef ECLAIR_MUL_SAT_EN
    localparam int RW = dout_WIDTH + 1;
`else
    localparam int RW = dout_WIDTH;
`endif

    function automatic logic [PW-1:0] mul(input logic [PW-1:0] ops);
        logic [din0_WIDTH-1:0] a = ops[PW-1 -: din0_WIDTH];
        logic [din1_WIDTH-1:0] b = ops[din1_WIDTH-1:0];
        logic signed [din0_WIDTH:0] ae = {(DIN0_SIGNED != 0) && a[din0_WIDTH-1], a};
        logic signed [din1_WIDTH:0] be = {(DIN1_SIGNED != 0) && b[din1_WIDTH-1], b};
        return PW'(ae) * PW'(be);
    endfunction

    function automatic logic [RW-1:0] res(input logic [PW-1:0] p);
        wide_t e = {{(MAXW - PW){RS && p[PW-1]}}, p};
        wide_t r = round_shift(e, FRAC_SHIFT);
`ifdef ECLAIR_MUL_SAT_EN
        wide_t f = fit(r, dout_WIDTH, RS, 1'b1);
        return {f != r, dout_WIDTH'(f)};
`else
        return dout_WIDTH'(r);
`endif
    endfunction

    logic [NUM_STAGE-1:0] w_sv;
    logic [PW-1:0]        w_q [NQ];
    logic [RW-1:0]        w_res;

    // A stage can take new data if any stage at or after it is empty, or the output drains.
    assign in_ready  = out_ready || !(&w_sv);
    assign out_valid = w_sv[NUM_STAGE-1];
    assign dout      = w_res[dout_WIDTH-1:0];
`ifdef ECLAIR_MUL_SAT_EN
    assign sat_flag  = w_res[dout_WIDTH];
`endif

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_s
        logic w_iv, w_dr;
        if (k == 0) begin : g_v0
            assign w_iv = in_valid;
        end else begin : g_vk
            assign w_iv = w_sv[k-1];
        end
        if (k == NUM_STAGE - 1) begin : g_rl
            assign w_dr = out_ready;
        end else begin : g_rk
            assign w_dr = out_ready || !(&w_sv[NUM_STAGE-1:k+1]);
        end
        if (k == NUM_STAGE - 1) begin : g_last
            logic [RW-1:0] w_d;
            if (k == 0) begin : g_d0
                assign w_d = res(mul({din0, din1}));
            end else if (k == 1) begin : g_d1
                assign w_d = res(mul(w_q[0]));
            end else begin : g_dk
                assign w_d = res(w_q[k-1]);
            end
            eclair_pipe_stage #(.W(RW)) u_stage (
                .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_valid(w_iv), .i_data(w_d),
                .i_ready(w_dr), .o_valid(w_sv[k]), .o_data(w_res)
            );
        end else begin : g_mid
            logic [PW-1:0] w_d;
            if (k == 0) begin : g_d0
                assign w_d = {din0, din1};
            end else if (k == 1) begin : g_d1
                assign w_d = mul(w_q[0]);
            end else begin : g_dk
                assign w_d = w_q[k-1];
            end
            eclair_pipe_stage #(.W(PW)) u_stage (
                .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_valid(w_iv), .i_data(w_d),
                .i_ready(w_dr), .o_valid(w_sv[k]), .o_data(w_q[k])
            );
        end
    end
endmodule

// File: tb/tb_eclair_mul_pipe.sv
// tb_eclair_mul_pipe: scoreboard bench for eclair_mul_pipe over three parameter sets.
module tb_eclair_mul_pipe;
    logic ap_clk = 1'b0, ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [15:0] a_d0 = '0;
    logic [8:0]  a_d1 = '0;
    logic        a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov;
    logic [24:0] a_do;
    logic [15:0] b_d0 = '0;
    logic [8:0]  b_d1 = '0;
    logic        b_iv = 1'b0, b_or = 1'b1, b_ir, b_ov;
    logic [15:0] b_do;
    logic [3:0]  c_d0 = '0, c_d1 = '0;
    logic        c_iv = 1'b0, c_or = 1'b1, c_ir, c_ov;
    logic [7:0]  c_do;
`ifdef ECLAIR_MUL_SAT_EN
    logic a_sat, b_sat, c_sat;
`endif

    eclair_mul_pipe u_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(a_d0), .din1(a_d1), .in_valid(a_iv),
        .in_ready(a_ir), .dout(a_do), .out_valid(a_ov),
`ifdef ECLAIR_MUL_SAT_EN
        .sat_flag(a_sat),
`endif
        .out_ready(a_or)
    );
    eclair_mul_pipe #(.NUM_STAGE(3), .dout_WIDTH(16), .FRAC_SHIFT(8)) u_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(b_d0), .din1(b_d1), .in_valid(b_iv),
        .in_ready(b_ir), .dout(b_do), .out_valid(b_ov),
`ifdef ECLAIR_MUL_SAT_EN
        .sat_flag(b_sat),
`endif
        .out_ready(b_or)
    );
    eclair_mul_pipe #(.NUM_STAGE(1), .din0_WIDTH(4), .din1_WIDTH(4), .dout_WIDTH(8),
                      .DIN0_SIGNED(1), .DIN1_SIGNED(1), .FRAC_SHIFT(1)) u_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(c_d0), .din1(c_d1), .in_valid(c_iv),
        .in_ready(c_ir), .dout(c_do), .out_valid(c_ov),
`ifdef ECLAIR_MUL_SAT_EN
        .sat_flag(c_sat),
`endif
        .out_ready(c_or)
    );

    typedef struct { logic [24:0] d; int t; bit lat; } item_t;
    item_t q[$];
    int checks = 0, failures = 0, cyc = 0, out_cnt = 0;
    bit lat_mode = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] model_a(input logic [15:0] d0, input logic [8:0] d1);
        longint p = longint'($signed(d0)) * longint'(d1);
        return p[24:0];
    endfunction

    always @(negedge ap_clk) begin
        item_t it;
        if (ap_rst_n && a_ov && a_or) begin
            chk("a_out_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                it = q.pop_front();
                out_cnt++;
                chk("a_dout", a_do, it.d);
                if (it.lat) chk("a_latency", cyc - it.t, 2);
`ifdef ECLAIR_MUL_SAT_EN
                chk("a_sat", a_sat, 0);
`endif
            end
        end
        if (ap_rst_n && a_iv && a_ir) q.push_back('{model_a(a_d0, a_d1), cyc, lat_mode});
    end

    task automatic send_a(input logic [15:0] d0, input logic [8:0] d1);
        int n = 0;
        @(posedge ap_clk); #1;
        a_iv = 1'b1; a_d0 = d0; a_d1 = d1;
        @(negedge ap_clk);
        while (!a_ir && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        chk("a_accept", a_ir, 1);
    endtask

    task automatic idle_a();
        @(posedge ap_clk); #1;
        a_iv = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            @(posedge ap_clk);
            n++;
        end
        chk("a_drained", q.size(), 0);
    endtask

    task automatic run_b(input logic [15:0] d0, input logic [8:0] d1, input logic [15:0] e,
                         input logic es, input string tag);
        int n = 0;
        @(posedge ap_clk); #1;
        b_iv = 1'b1; b_d0 = d0; b_d1 = d1;
        @(negedge ap_clk);
        chk({tag, "_in_ready"}, b_ir, 1);
        @(posedge ap_clk); #1;
        b_iv = 1'b0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!b_ov && n < 20);
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_dout"}, b_do, e);
`ifdef ECLAIR_MUL_SAT_EN
        chk({tag, "_sat"}, b_sat, es);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, c, sacc, oc0;
        logic [24:0] held;
        bit hv;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_out_valid", a_ov, 0);
        chk("rst_dout", a_do, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        #1;
        chk("rst_in_ready_a", a_ir, 1);
        chk("rst_in_ready_b", b_ir, 1);
        chk("rst_in_ready_c", c_ir, 1);

        // full-scale product and back-to-back stream with exact latency
        lat_mode = 1'b1;
        send_a(16'h8000, 9'd511);
        send_a(16'd1, 9'd1);
        send_a(16'hFFFF, 9'd511);
        send_a(16'd12345, 9'd300);
        idle_a();
        lat_mode = 1'b0;
        drain_a();

        // rounding, negative rounding and overflow on the 3-stage 16-bit instance
        run_b(16'd1000, 9'd300, 16'd1172, 1'b0, "b_round_up");
        run_b(-16'sd1000, 9'd300, 16'hFB6C, 1'b0, "b_round_neg");
`ifdef ECLAIR_MUL_SAT_EN
        run_b(16'd32767, 9'd511, 16'd32767, 1'b1, "b_clamp");
`else
        run_b(16'd32767, 9'd511, 16'hFF7E, 1'b0, "b_wrap");
`endif

        // single-stage signed 4x4: tie rounding and in_ready = !out_valid || out_ready
        @(posedge ap_clk); #1;
        c_iv = 1'b1; c_d0 = 4'hD; c_d1 = 4'h1; c_or = 1'b1;
        @(negedge ap_clk);
        chk("c_in_ready_empty", c_ir, 1);
        @(posedge ap_clk); #1;
        c_d0 = 4'h5; c_d1 = 4'hE; c_or = 1'b0;
        @(negedge ap_clk);
        chk("c_out_valid", c_ov, 1);
        chk("c_tie_dout", c_do, 8'hFF);
        chk("c_in_ready_full", c_ir, 0);
        @(posedge ap_clk); #1;
        c_or = 1'b1;
        @(negedge ap_clk);
        chk("c_in_ready_drain", c_ir, 1);
        chk("c_hold_dout", c_do, 8'hFF);
        @(posedge ap_clk); #1;
        c_iv = 1'b0;
        @(negedge ap_clk);
        chk("c_out_valid2", c_ov, 1);
        chk("c_neg_dout", c_do, 8'hFB);
`ifdef ECLAIR_MUL_SAT_EN
        chk("c_sat", c_sat, 0);
`endif

        // back-pressure: drain, then stall 5 cycles while streaming 10 ascending items
        oc0 = out_cnt; sent = 0; c = 0; sacc = 0; hv = 1'b0; held = '0;
        while (sent < 10 && c < 100) begin
            @(posedge ap_clk); #1;
            a_or = !(c >= 4 && c < 9);
            a_iv = !(c == 2 || c == 3);
            a_d0 = 16'(100 + 7 * sent); a_d1 = 9'd5;
            @(negedge ap_clk);
            if (!a_or && a_ov) begin
                if (hv) chk("a_stall_hold", a_do, held);
                held = a_do;
                hv = 1'b1;
            end
            if (c == 8) chk("a_stall_in_ready", a_ir, 0);
            if (a_iv && a_ir) begin
                sent++;
                if (!a_or) sacc++;
            end
            c++;
        end
        chk("a_stall_accepts", sacc, 2);
        idle_a();
        a_or = 1'b1;
        drain_a();
        chk("a_stream_count", out_cnt - oc0, 10);

        // asynchronous reset with two items in flight
        send_a(16'd50, 9'd3);
        send_a(16'd60, 9'd3);
        @(posedge ap_clk); #1;
        a_iv = 1'b0;
        chk("a_inflight_valid", a_ov, 1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", a_ov, 0);
        chk("arst_dout", a_do, 0);
        q.delete();
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        #1;
        chk("arst_in_ready", a_ir, 1);
        repeat (6) @(posedge ap_clk);
        #1;
        chk("arst_no_stale", a_ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
